// File: rtl/lif_soma.sv
// -----------------------------------------------------------------------------
// lif_soma -- leaky integrate-and-fire soma
//
// Accumulates signed synaptic weights into a saturating membrane potential,
// bleeds a fraction of the potential away every LEAK_PERIOD enabled cycles,
// and emits a one-cycle spike when the potential reaches the threshold.
// After a spike the soma ignores its inputs for `refractory` enabled cycles.
//
// Ports
//   clock             in   rising-edge system clock
//   reset             in   asynchronous, active-high reset
//   enable            in   low: every register holds, spike_out is cleared
//   syn_spike         in   [N_SYN]          per-synapse spike strobes
//   syn_weight        in   [N_SYN*W_WIDTH]  packed signed weights, syn i at [i*W_WIDTH +: W_WIDTH]
//   threshold         in   [V_WIDTH]        signed firing threshold (legal values are > 0)
//   refractory        in   [6]              refractory length, captured at each fire
//   spike_out         out  registered one-cycle fire pulse (feeds the axon delay stage)
//   v_mem             out  [V_WIDTH]        registered signed membrane potential
//   refractory_active out  high while the soma is refractory
// -----------------------------------------------------------------------------
module lif_soma #(
    parameter int N_SYN       = 4,
    parameter int W_WIDTH     = 8,
    parameter int V_WIDTH     = 16,
    parameter int LEAK_SHIFT  = 3,
    parameter int LEAK_PERIOD = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_SYN-1:0]          syn_spike,
    input  logic [N_SYN*W_WIDTH-1:0]  syn_weight,
    input  logic signed [V_WIDTH-1:0] threshold,
    input  logic [5:0]                refractory,
    output logic                      spike_out,
    output logic signed [V_WIDTH-1:0] v_mem,
    output logic                      refractory_active
);

    // Wide enough that potential, leak and the full synaptic sum never wrap
    // before saturation is applied.
    localparam int SUM_W  = V_WIDTH + $clog2(N_SYN) + 1;
    localparam int LCNT_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;

    localparam logic [LCNT_W-1:0]      LEAK_LAST = LCNT_W'(LEAK_PERIOD - 1);
    localparam logic signed [SUM_W-1:0] V_MAX_EXT = SUM_W'((2 ** (V_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0] V_MIN_EXT = ~V_MAX_EXT;

    typedef enum logic [0:0] {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } state_t;

    // Sign-extend one synaptic weight to the accumulator width.
    function automatic logic signed [SUM_W-1:0] sext_w(input logic [W_WIDTH-1:0] w);
        return {{(SUM_W - W_WIDTH){w[W_WIDTH-1]}}, w};
    endfunction

    // Sign-extend the membrane potential to the accumulator width.
    function automatic logic signed [SUM_W-1:0] sext_v(input logic [V_WIDTH-1:0] v);
        return {{(SUM_W - V_WIDTH){v[V_WIDTH-1]}}, v};
    endfunction

    // Clamp a wide accumulator value into the signed membrane range.
    function automatic logic signed [V_WIDTH-1:0] sat_v(input logic signed [SUM_W-1:0] x);
        logic signed [V_WIDTH-1:0] r;
        if (x > V_MAX_EXT) begin
            r = V_MAX_EXT[V_WIDTH-1:0];
        end else if (x < V_MIN_EXT) begin
            r = V_MIN_EXT[V_WIDTH-1:0];
        end else begin
            r = x[V_WIDTH-1:0];
        end
        return r;
    endfunction

    state_t                     state_r;
    state_t                     state_nxt_s;
    logic signed [V_WIDTH-1:0]  v_mem_r;
    logic signed [V_WIDTH-1:0]  v_mem_nxt_s;
    logic                       spike_r;
    logic                       spike_nxt_s;
    logic [5:0]                 refr_cnt_r;
    logic [5:0]                 refr_cnt_nxt_s;
    logic [LCNT_W-1:0]          leak_cnt_r;
    logic [LCNT_W-1:0]          leak_cnt_nxt_s;

    logic                       leak_tick_s;
    logic signed [SUM_W-1:0]    sum_s;
    logic signed [SUM_W-1:0]    leak_s;
    logic signed [SUM_W-1:0]    raw_s;
    logic signed [V_WIDTH-1:0]  v_next_s;
    logic                       fire_s;

    assign leak_tick_s = (leak_cnt_r == LEAK_LAST);

    // Synaptic sum, leak term and the saturated candidate potential.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < N_SYN; i++) begin
            sum_s = sum_s + (syn_spike[i] ? sext_w(syn_weight[i*W_WIDTH +: W_WIDTH])
                                          : {SUM_W{1'b0}});
        end

        // Arithmetic shift rounds toward -inf, so a negative potential's leak is
        // itself negative and subtracting it pulls the potential up toward 0.
        if (leak_tick_s) begin
            leak_s = sext_v(v_mem_r) >>> LEAK_SHIFT;
        end else begin
            leak_s = '0;
        end

        raw_s    = sext_v(v_mem_r) - leak_s + sum_s;
        v_next_s = sat_v(raw_s);
        fire_s   = (v_next_s >= threshold);
    end

    // Next-state and next-output logic for the INTEGRATE/REFRACTORY machine.
    always_comb begin
        state_nxt_s    = state_r;
        v_mem_nxt_s    = v_mem_r;
        spike_nxt_s    = 1'b0;
        refr_cnt_nxt_s = refr_cnt_r;
        leak_cnt_nxt_s = leak_cnt_r;

        if (enable) begin
            // The leak phase keeps running through refractory periods.
            if (leak_tick_s) begin
                leak_cnt_nxt_s = '0;
            end else begin
                leak_cnt_nxt_s = leak_cnt_r + LCNT_W'(1);
            end

            case (state_r)
                ST_INTEGRATE: begin
                    if (fire_s) begin
                        spike_nxt_s    = 1'b1;
                        v_mem_nxt_s    = '0;
                        refr_cnt_nxt_s = refractory;
                        // A zero-length refractory keeps integrating, allowing
                        // back-to-back pulses under sustained drive.
                        if (refractory != 6'd0) begin
                            state_nxt_s = ST_REFRACTORY;
                        end else begin
                            state_nxt_s = ST_INTEGRATE;
                        end
                    end else begin
                        v_mem_nxt_s = v_next_s;
                    end
                end
                ST_REFRACTORY: begin
                    v_mem_nxt_s    = '0;
                    refr_cnt_nxt_s = refr_cnt_r - 6'd1;
                    // Leaving on a count of 1 yields exactly `refractory`
                    // ignored edges, counting the one that leaves.
                    if (refr_cnt_r <= 6'd1) begin
                        state_nxt_s = ST_INTEGRATE;
                    end else begin
                        state_nxt_s = ST_REFRACTORY;
                    end
                end
                default: begin
                    state_nxt_s    = ST_INTEGRATE;
                    v_mem_nxt_s    = '0;
                    refr_cnt_nxt_s = 6'd0;
                end
            endcase
        end else begin
            spike_nxt_s = 1'b0;
        end
    end

    // State, membrane and counter registers; reset returns to a quiet INTEGRATE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_INTEGRATE;
            v_mem_r    <= '0;
            spike_r    <= 1'b0;
            refr_cnt_r <= 6'd0;
            leak_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            v_mem_r    <= v_mem_nxt_s;
            spike_r    <= spike_nxt_s;
            refr_cnt_r <= refr_cnt_nxt_s;
            leak_cnt_r <= leak_cnt_nxt_s;
        end
    end

    assign spike_out         = spike_r;
    assign v_mem             = v_mem_r;
    assign refractory_active = (state_r == ST_REFRACTORY);

endmodule

// File: tb/tb_lif_soma.sv
// -----------------------------------------------------------------------------
// tb_lif_soma -- scoreboard bench for lif_soma
//
// The stimulus process drives inputs on the falling edge and queues the
// expected outputs for the following rising edge. An independent monitor
// samples the outputs 1 time unit after each rising edge and compares them
// against the queued entry tagged with that edge number.
// -----------------------------------------------------------------------------
module tb_lif_soma;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic [3:0]         syn_spike;
    logic [31:0]        syn_weight;
    logic signed [15:0] threshold;
    logic [5:0]         refractory;
    logic               spike_out;
    logic signed [15:0] v_mem;
    logic               refractory_active;

    typedef struct packed {
        logic [31:0] edge_no;
        logic        spk;
        logic [15:0] v;
        logic        ra;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    edge_n = 0;
    int    checks = 0;
    int    errors = 0;

    always #5 clock = ~clock;

    lif_soma #(
        .N_SYN       (4),
        .W_WIDTH     (8),
        .V_WIDTH     (16),
        .LEAK_SHIFT  (3),
        .LEAK_PERIOD (16)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .syn_spike         (syn_spike),
        .syn_weight        (syn_weight),
        .threshold         (threshold),
        .refractory        (refractory),
        .spike_out         (spike_out),
        .v_mem             (v_mem),
        .refractory_active (refractory_active)
    );

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Drive one cycle of stimulus (at a falling edge) and optionally queue the
    // outputs expected after the next rising edge.
    task automatic step(input logic [3:0] spk, input bit chk, input logic e_spk,
                        input int e_v, input logic e_ra, input string nm);
        exp_t e;
        syn_spike = spk;
        if (chk) begin
            e.edge_no = 32'(edge_n + 1);
            e.spk     = e_spk;
            e.v       = 16'(e_v);
            e.ra      = e_ra;
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(negedge clock);
    endtask

    task automatic set_w(input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3);
        syn_weight = {w3, w2, w1, w0};
    endtask

    // Leaves the bench on a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        syn_spike = 4'b0000;
        enable    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: compare every queued expectation against the sampled outputs.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clock);
            #1;
            edge_n++;
            while (exp_q.size() > 0 && int'(exp_q[0].edge_no) <= edge_n) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, "_edge"}, int'(e.edge_no), edge_n);
                check({nm, "_spk"}, int'(spike_out), int'(e.spk));
                check({nm, "_v"}, int'(v_mem), int'($signed(e.v)));
                check({nm, "_ra"}, int'(refractory_active), int'(e.ra));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        syn_spike  = 4'b0000;
        syn_weight = 32'd0;
        threshold  = 16'sd40;
        refractory = 6'd0;

        // 1: reset in the middle of a refractory period, right after a fire.
        do_reset();
        set_w(8'd40, 8'd0, 8'd0, 8'd0);
        threshold  = 16'sd40;
        refractory = 6'd20;
        step(4'b0001, 1'b1, 1'b1, 0, 1'b1, "t1_fire");
        syn_spike = 4'b0000;
        #2;
        reset = 1'b1;
        #1;
        check("t1_rst_spk", int'(spike_out), 0);
        check("t1_rst_v", int'(v_mem), 0);
        check("t1_rst_ra", int'(refractory_active), 0);
        @(negedge clock);
        reset = 1'b0;
        set_w(8'd15, 8'd0, 8'd0, 8'd0);
        refractory = 6'd0;
        step(4'b0001, 1'b1, 1'b0, 15, 1'b0, "t1_integ");

        // 2: integrate 10 per edge to a threshold of 40.
        do_reset();
        set_w(8'd10, 8'd0, 8'd0, 8'd0);
        threshold  = 16'sd40;
        refractory = 6'd0;
        step(4'b0001, 1'b1, 1'b0, 10, 1'b0, "t2_v10");
        step(4'b0001, 1'b1, 1'b0, 20, 1'b0, "t2_v20");
        step(4'b0001, 1'b1, 1'b0, 30, 1'b0, "t2_v30");
        step(4'b0001, 1'b1, 1'b1, 0, 1'b0, "t2_fire");
        step(4'b0000, 1'b1, 1'b0, 0, 1'b0, "t2_after");

        // 3: refractory of 3 with input held; a mid-period change is ignored.
        do_reset();
        set_w(8'd40, 8'd0, 8'd0, 8'd0);
        threshold  = 16'sd40;
        refractory = 6'd3;
        step(4'b0001, 1'b1, 1'b1, 0, 1'b1, "t3_fire1");
        refractory = 6'd10;
        step(4'b0001, 1'b1, 1'b0, 0, 1'b1, "t3_refr1");
        step(4'b0001, 1'b1, 1'b0, 0, 1'b1, "t3_refr2");
        step(4'b0001, 1'b1, 1'b0, 0, 1'b0, "t3_refr3");
        step(4'b0001, 1'b1, 1'b1, 0, 1'b1, "t3_fire2");
        refractory = 6'd0;

        // 4: leak of 80 -> 70 at edge 16 -> 62 at edge 32.
        do_reset();
        set_w(8'd80, 8'd0, 8'd0, 8'd0);
        threshold = 16'sd100;
        step(4'b0001, 1'b1, 1'b0, 80, 1'b0, "t4_load");
        for (int k = 2; k <= 33; k++) begin
            step(4'b0000, 1'b1, 1'b0, (k < 16) ? 80 : ((k < 32) ? 70 : 62), 1'b0, "t4_leak");
        end

        // 4b: leak of -1 reaches 0 at the first tick.
        do_reset();
        set_w(8'hFF, 8'd0, 8'd0, 8'd0);
        step(4'b0001, 1'b1, 1'b0, -1, 1'b0, "t4b_load");
        for (int k = 2; k <= 17; k++) begin
            step(4'b0000, 1'b1, 1'b0, (k < 16) ? -1 : 0, 1'b0, "t4b_leak");
        end

        // 5: simultaneous spikes, then negative saturation.
        do_reset();
        set_w(8'd50, 8'hEC, 8'd30, 8'd0);
        threshold = 16'sd32767;
        step(4'b1111, 1'b1, 1'b0, 60, 1'b0, "t5_sum");
        set_w(8'h80, 8'h80, 8'h80, 8'h80);
        step(4'b1111, 1'b1, 1'b0, -452, 1'b0, "t5_neg");
        for (int k = 3; k <= 200; k++) begin
            step(4'b1111, (k == 191 || k == 192 || k == 193 || k == 199 || k == 200),
                 1'b0, (k == 192) ? -29184 : ((k == 193) ? -29696 : -32768), 1'b0, "t5_sat");
        end

        // 6: enable low freezes v_mem and the leak phase.
        do_reset();
        set_w(8'd80, 8'd0, 8'd0, 8'd0);
        threshold = 16'sd100;
        step(4'b0001, 1'b1, 1'b0, 80, 1'b0, "t6_load");
        for (int k = 2; k <= 5; k++) begin
            step(4'b0000, 1'b1, 1'b0, 80, 1'b0, "t6_pre");
        end
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(4'b0001, 1'b1, 1'b0, 80, 1'b0, "t6_hold");
        end
        enable = 1'b1;
        for (int k = 6; k <= 16; k++) begin
            step(4'b0000, 1'b1, 1'b0, (k < 16) ? 80 : 70, 1'b0, "t6_resume");
        end

        // 6b: enable low freezes the refractory count.
        do_reset();
        set_w(8'd40, 8'd0, 8'd0, 8'd0);
        threshold  = 16'sd40;
        refractory = 6'd2;
        step(4'b0001, 1'b1, 1'b1, 0, 1'b1, "t6b_fire");
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(4'b0001, 1'b1, 1'b0, 0, 1'b1, "t6b_hold");
        end
        enable = 1'b1;
        step(4'b0001, 1'b1, 1'b0, 0, 1'b1, "t6b_refr1");
        step(4'b0001, 1'b1, 1'b0, 0, 1'b0, "t6b_refr2");
        step(4'b0001, 1'b1, 1'b1, 0, 1'b1, "t6b_fire2");

        // 7: threshold of 0 fires on every integrating edge.
        do_reset();
        set_w(8'd0, 8'd0, 8'd0, 8'd0);
        threshold  = 16'sd0;
        refractory = 6'd0;
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, 1'b1, 1'b1, 0, 1'b0, "t7_thr0");
        end

        repeat (3) @(negedge clock);
        check("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
